// File: rtl/tusca_controle_clima.sv
// Climate-control sequencer: periodically requests a DHT11 measurement,
// waits for it under a timeout, then applies hysteresis/threshold rules to
// drive the cooling relay, the fan duty level and the vent servo.
// Repeated sensor failures latch a fail-safe ERRO state.
// Handshake: medir_dht11 is a 1-cycle request; the sensor answers with a
// 1-cycle pronto_medida (data valid in that cycle) or erro_medida pulse.
module tusca_controle_clima #(
  parameter int PERIODO_MEDIDA = 100_000_000,
  parameter int TIMEOUT_MEDIDA = 2_500_000,
  parameter int MAX_FALHAS     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       liga,
  input  logic       config_valida,
  input  logic [7:0] temp_limite,
  input  logic [3:0] histerese,
  input  logic [7:0] umid_limite,
  input  logic       pronto_medida,
  input  logic       erro_medida,
  input  logic [7:0] temperatura,
  input  logic [7:0] umidade,
  output logic       medir_dht11,
  output logic       rele,
  output logic [1:0] duty_ventoinha,
  output logic [1:0] posicao_servo,
  output logic       erro_sensor,
  output logic [1:0] falhas,
  output logic [3:0] db_estado
);

  localparam int W_P = (PERIODO_MEDIDA > 1) ? $clog2(PERIODO_MEDIDA) : 1;
  localparam int W_T = (TIMEOUT_MEDIDA > 1) ? $clog2(TIMEOUT_MEDIDA) : 1;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    MEDIR    = 4'd2,
    AGUARDA  = 4'd3,
    AVALIA   = 4'd4,
    ATUALIZA = 4'd5,
    FALHA    = 4'd6,
    ERRO     = 4'd15
  } estado_t;

  estado_t        estado, estado_prox;
  logic [W_P-1:0] cont_periodo;
  logic [W_T-1:0] cont_timeout;
  logic [7:0]     t_lat, h_lat;
  logic           fim_periodo, fim_timeout;
  logic [1:0]     falhas_inc;

  // Rule results and next output values
  logic [7:0] lim_baixo, lim_alto, dif_temp;
  logic [8:0] soma_umid;
  logic       rele_regra;
  logic [1:0] duty_regra, servo_regra;
  logic       medir_d, rele_d, erro_d;
  logic [1:0] duty_d, servo_d, falhas_d;

  assign fim_periodo = (cont_periodo == W_P'(PERIODO_MEDIDA - 1));
  assign fim_timeout = (cont_timeout == W_T'(TIMEOUT_MEDIDA - 1));
  assign falhas_inc  = (falhas >= 2'(MAX_FALHAS)) ? falhas : falhas + 2'd1;
  assign db_estado   = estado;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

  // Next-state logic; liga=0 overrides every transition
  always_comb begin
    estado_prox = estado;
    if (!liga) begin
      estado_prox = INICIAL;
    end else begin
      case (estado)
        INICIAL:  if (config_valida) estado_prox = ESPERA;
        ESPERA:   if (fim_periodo) estado_prox = MEDIR;
        MEDIR:    estado_prox = AGUARDA;
        AGUARDA: begin
          // pronto wins over a simultaneous erro
          if (pronto_medida)                    estado_prox = AVALIA;
          else if (erro_medida || fim_timeout)  estado_prox = FALHA;
        end
        AVALIA:   estado_prox = ATUALIZA;
        ATUALIZA: estado_prox = ESPERA;
        FALHA:    estado_prox = (falhas_inc == 2'(MAX_FALHAS)) ? ERRO : ESPERA;
        ERRO:     estado_prox = ERRO;
        default:  estado_prox = INICIAL;
      endcase
    end
  end

  // Period counter runs only while waiting in ESPERA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        cont_periodo <= '0;
    else if (estado == ESPERA && estado_prox == ESPERA) cont_periodo <= cont_periodo + W_P'(1);
    else                                               cont_periodo <= '0;
  end

  // Timeout counter runs only while waiting for the sensor answer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  cont_timeout <= '0;
    else if (estado == AGUARDA)  cont_timeout <= cont_timeout + W_T'(1);
    else                         cont_timeout <= '0;
  end

  // Latch the measurement on the pronto pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t_lat <= '0;
      h_lat <= '0;
    end else if (estado == AGUARDA && pronto_medida) begin
      t_lat <= temperatura;
      h_lat <= umidade;
    end
  end

  // Threshold rules on the latched measurement; thresholds are read live
  always_comb begin
    lim_baixo = (temp_limite > {4'd0, histerese}) ? temp_limite - {4'd0, histerese} : 8'd0;
    soma_umid = {1'b0, umid_limite} + 9'd10;
    lim_alto  = soma_umid[8] ? 8'hFF : soma_umid[7:0];
    dif_temp  = t_lat - temp_limite;

    // A saturated lower bound of 0 can never be undercut, so the relay holds
    if (t_lat >= temp_limite)   rele_regra = 1'b1;
    else if (t_lat < lim_baixo) rele_regra = 1'b0;
    else                        rele_regra = rele;

    if (t_lat < temp_limite)    duty_regra = 2'd0;
    else if (dif_temp <= 8'd1)  duty_regra = 2'd1;
    else if (dif_temp <= 8'd4)  duty_regra = 2'd2;
    else                        duty_regra = 2'd3;

    if (h_lat < umid_limite)    servo_regra = 2'd0;
    else if (h_lat < lim_alto)  servo_regra = 2'd1;
    else                        servo_regra = 2'd2;
  end

  // Output logic: values loaded on the edge leaving AVALIA appear in ATUALIZA
  always_comb begin
    medir_d  = (estado_prox == MEDIR);
    rele_d   = rele;
    duty_d   = duty_ventoinha;
    servo_d  = posicao_servo;
    erro_d   = erro_sensor;
    falhas_d = falhas;
    if (!liga) begin
      rele_d   = 1'b0;
      duty_d   = 2'd0;
      servo_d  = 2'd0;
      erro_d   = 1'b0;
      falhas_d = 2'd0;
    end else begin
      case (estado)
        AVALIA: begin
          rele_d   = rele_regra;
          duty_d   = duty_regra;
          servo_d  = servo_regra;
          falhas_d = 2'd0;
        end
        FALHA:   falhas_d = falhas_inc;
        default: ;
      endcase
      // Fail-safe: relay off, fan max, vent fully open
      if (estado_prox == ERRO) begin
        rele_d  = 1'b0;
        duty_d  = 2'd3;
        servo_d = 2'd2;
        erro_d  = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      medir_dht11    <= 1'b0;
      rele           <= 1'b0;
      duty_ventoinha <= 2'd0;
      posicao_servo  <= 2'd0;
      erro_sensor    <= 1'b0;
      falhas         <= 2'd0;
    end else begin
      medir_dht11    <= medir_d;
      rele           <= rele_d;
      duty_ventoinha <= duty_d;
      posicao_servo  <= servo_d;
      erro_sensor    <= erro_d;
      falhas         <= falhas_d;
    end
  end

endmodule

// File: tb/tb_tusca_controle_clima.sv
// Testbench for tusca_controle_clima: directed scenarios plus randomized
// measurements, checked by a scoreboard fed from a behavioural model.
module tb_tusca_controle_clima;

  localparam int P    = 20;
  localparam int TO   = 10;
  localparam int MAXF = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       liga = 1'b0, config_valida = 1'b0;
  logic [7:0] temp_limite = 8'd0, umid_limite = 8'd0;
  logic [3:0] histerese = 4'd0;
  logic       pronto_medida = 1'b0, erro_medida = 1'b0;
  logic [7:0] temperatura = 8'd0, umidade = 8'd0;
  logic       medir_dht11, rele, erro_sensor;
  logic [1:0] duty_ventoinha, posicao_servo, falhas;
  logic [3:0] db_estado;

  tusca_controle_clima #(
    .PERIODO_MEDIDA(P), .TIMEOUT_MEDIDA(TO), .MAX_FALHAS(MAXF)
  ) dut (
    .clock(clock), .reset(reset), .liga(liga), .config_valida(config_valida),
    .temp_limite(temp_limite), .histerese(histerese), .umid_limite(umid_limite),
    .pronto_medida(pronto_medida), .erro_medida(erro_medida),
    .temperatura(temperatura), .umidade(umidade),
    .medir_dht11(medir_dht11), .rele(rele), .duty_ventoinha(duty_ventoinha),
    .posicao_servo(posicao_servo), .erro_sensor(erro_sensor), .falhas(falhas),
    .db_estado(db_estado)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] estado;
    logic       rele;
    logic [1:0] duty;
    logic [1:0] servo;
    logic       erro;
    logic [1:0] falhas;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: what the outputs should be after the last event
  int m_rele = 0, m_duty = 0, m_servo = 0, m_falhas = 0;
  bit m_erro = 1'b0;

  task automatic check(input string nome, input int atual, input int esperado);
    n_checks++;
    if (atual == esperado) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
  endtask

  function automatic obs_t monta(int est, int r, int d, int s, int er, int f);
    obs_t o;
    o.estado = 4'(est);
    o.rele   = 1'(r);
    o.duty   = 2'(d);
    o.servo  = 2'(s);
    o.erro   = 1'(er);
    o.falhas = 2'(f);
    return o;
  endfunction

  function automatic obs_t observa();
    obs_t o;
    o.estado = db_estado;
    o.rele   = rele;
    o.duty   = duty_ventoinha;
    o.servo  = posicao_servo;
    o.erro   = erro_sensor;
    o.falhas = falhas;
    return o;
  endfunction

  function automatic void modelo_reset();
    m_rele = 0; m_duty = 0; m_servo = 0; m_falhas = 0; m_erro = 1'b0;
  endfunction

  // Successful measurement: apply the threshold rules with plain integers
  function automatic void modelo_ok(int t, int h);
    int tl, hi, ul, lb, la;
    tl = int'(temp_limite);
    hi = int'(histerese);
    ul = int'(umid_limite);
    lb = (tl - hi < 0) ? 0 : tl - hi;
    la = (ul + 10 > 255) ? 255 : ul + 10;
    if (t >= tl)     m_rele = 1;
    else if (t < lb) m_rele = 0;
    if (t < tl)               m_duty = 0;
    else if (t - tl <= 1)     m_duty = 1;
    else if (t - tl <= 4)     m_duty = 2;
    else                      m_duty = 3;
    if (h < ul)      m_servo = 0;
    else if (h < la) m_servo = 1;
    else             m_servo = 2;
    m_falhas = 0;
    exp_q.push_back(monta(5, m_rele, m_duty, m_servo, 0, 0));
  endfunction

  // Failed measurement: count up, fall into fail-safe on the last one
  function automatic void modelo_falha();
    m_falhas = (m_falhas + 1 > MAXF) ? MAXF : m_falhas + 1;
    if (m_falhas == MAXF) begin
      m_erro = 1'b1; m_rele = 0; m_duty = 3; m_servo = 2;
      exp_q.push_back(monta(15, 0, 3, 2, 1, m_falhas));
    end else begin
      exp_q.push_back(monta(1, m_rele, m_duty, m_servo, 0, m_falhas));
    end
  endfunction

  // Monitor: compares on first ATUALIZA cycle and on the cycle after FALHA
  logic [3:0] prev_estado = 4'd0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_estado = 4'd0;
    end else begin
      if ((db_estado == 4'd5 && prev_estado != 4'd5) || prev_estado == 4'd6) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: unexpected output event, state %0d", db_estado);
        end else begin
          obs_t e;
          e = exp_q.pop_front();
          check("saida", int'(observa()), int'(e));
        end
      end
      prev_estado = db_estado;
    end
  end

  // Driver tasks (all run at posedge + #1)
  task automatic espera_medir(input int lat);
    int  c;
    bit  achou;
    c = 0;
    achou = 1'b0;
    for (int i = 0; i < 4 * P; i++) begin
      @(posedge clock); #1;
      c++;
      if (medir_dht11) begin
        achou = 1'b1;
        break;
      end
    end
    if (!achou) begin
      n_checks++;
      $display("FAIL medir_timeout: no medir_dht11 pulse within %0d cycles", 4 * P);
    end else begin
      if (lat > 0) check("latencia_medir", c, lat);
      @(posedge clock); #1;
      check("medir_largura", int'(medir_dht11), 0);
    end
  endtask

  task automatic medicao_ok(input int t, input int h, input bit erro_junto, input int lat);
    int d;
    int ant;
    espera_medir(lat);
    d = int'($urandom_range(0, 5));
    repeat (d) begin @(posedge clock); #1; end
    ant = m_rele * 16 + m_duty * 4 + m_servo;
    temperatura   = 8'(t);
    umidade       = 8'(h);
    pronto_medida = 1'b1;
    erro_medida   = erro_junto;
    modelo_ok(t, h);
    @(posedge clock); #1;
    pronto_medida = 1'b0;
    erro_medida   = 1'b0;
    temperatura   = 8'($urandom);
    umidade       = 8'($urandom);
    // AVALIA: outputs not yet updated
    check("avalia_sem_mudanca", int'(rele) * 16 + int'(duty_ventoinha) * 4 + int'(posicao_servo), ant);
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  task automatic medicao_falha(input bit por_timeout, input int lat);
    int d;
    espera_medir(lat);
    modelo_falha();
    if (por_timeout) begin
      repeat (TO - 1) begin @(posedge clock); #1; end
      check("aguarda_ate_timeout", int'(db_estado), 3);
      @(posedge clock); #1;
      check("timeout_falha", int'(db_estado), 6);
    end else begin
      d = int'($urandom_range(0, 5));
      repeat (d) begin @(posedge clock); #1; end
      erro_medida = 1'b1;
      @(posedge clock); #1;
      erro_medida = 1'b0;
      check("erro_falha", int'(db_estado), 6);
    end
    @(posedge clock); #1;
  endtask

  task automatic desliga();
    liga = 1'b0;
    @(posedge clock); #1;
    check("desliga", int'({db_estado, rele, duty_ventoinha, posicao_servo,
                          erro_sensor, falhas, medir_dht11}), 0);
    modelo_reset();
    config_valida = 1'b1;
    liga = 1'b1;
  endtask

  // Main stimulus
  initial begin
    int prox_lat;
    bit medir_visto;
    reset = 1'b0; liga = 1'b1; config_valida = 1'b1;
    temp_limite = 8'd25; histerese = 4'd2; umid_limite = 8'd60;
    #12;
    check("reset_saidas", int'({db_estado, medir_dht11, rele, duty_ventoinha,
                               posicao_servo, erro_sensor, falhas}), 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // First measurement and hysteresis walk
    medicao_ok(27, 40, 1'b0, P + 1);
    medicao_ok(26, 40, 1'b0, 0);
    medicao_ok(24, 40, 1'b0, 0);
    medicao_ok(22, 40, 1'b0, 0);

    // Three timeouts in a row latch ERRO
    medicao_falha(1'b1, 0);
    medicao_falha(1'b1, 0);
    medicao_falha(1'b1, 0);
    medir_visto = 1'b0;
    repeat (2 * P) begin
      @(posedge clock); #1;
      if (medir_dht11) medir_visto = 1'b1;
    end
    check("erro_preso", int'({db_estado, medir_visto}), int'({4'd15, 1'b0}));
    desliga();

    // pronto and erro together: success wins, humidity limit saturates
    umid_limite = 8'd250;
    medicao_ok(30, 255, 1'b1, P + 1);

    // Asynchronous reset in the middle of AGUARDA
    temp_limite = 8'd20; umid_limite = 8'd10;
    medicao_ok(30, 50, 1'b0, 0);
    espera_medir(0);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("reset_assincrono", int'({db_estado, medir_dht11, rele, duty_ventoinha,
                                   posicao_servo, erro_sensor, falhas}), 0);
    modelo_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    medicao_ok(21, 15, 1'b0, P + 1);

    // Randomized measurements
    prox_lat = 0;
    for (int it = 0; it < 30; it++) begin
      int tl, t, h, kind;
      if ($urandom_range(0, 9) == 0) tl = int'($urandom_range(0, 4));
      else                           tl = int'($urandom_range(15, 40));
      temp_limite   = 8'(tl);
      histerese     = 4'($urandom_range(0, 15));
      umid_limite   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(240, 255))
                                                  : 8'($urandom_range(0, 255));
      config_valida = 1'($urandom_range(0, 1));
      t = tl + int'($urandom_range(0, 16)) - 8;
      if (t < 0)   t = 0;
      if (t > 255) t = 255;
      h = int'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      medicao_falha(1'b1, prox_lat);
      else if (kind == 1) medicao_falha(1'b0, prox_lat);
      else                medicao_ok(t, h, 1'($urandom_range(0, 3) == 0), prox_lat);
      prox_lat = 0;
      if (m_erro) begin
        desliga();
        prox_lat = P + 1;
      end
    end

    repeat (3) @(posedge clock);
    #1;
    check("fila_vazia", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tusca_controle_clima.md
Name: tusca_controle_clima

Overview:
- Climate-control sequencer for the TUSCA datapath.
- Periodically commands a DHT11 measurement and waits for its completion under a timeout.
- Applies hysteresis and threshold rules to the measured temperature and humidity, then drives the relay, the fan PWM duty level and the servo position.
- Sits between the serial-configuration registers, the DHT11 interface and the PWM generators, and replaces ad-hoc per-output control.

Parameters:
- PERIODO_MEDIDA, 100_000_000: clock cycles between measurement requests (2 s at 50 MHz).
- TIMEOUT_MEDIDA, 2_500_000: maximum cycles waiting for pronto_medida after a request.
- MAX_FALHAS, 3: consecutive failed measurements before the block latches the error state.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- liga  in  1  enable; 0 forces INICIAL with outputs cleared.
- config_valida  in  1  configuration registers hold a valid configuration.
- temp_limite  in  8  temperature threshold, °C.
- histerese  in  4  temperature hysteresis, °C.
- umid_limite  in  8  humidity threshold, %RH.
- pronto_medida  in  1  DHT11 interface: measurement finished OK, 1-cycle pulse.
- erro_medida  in  1  DHT11 interface: checksum or protocol error, 1-cycle pulse.
- temperatura  in  8  measured temperature, valid while pronto_medida=1.
- umidade  in  8  measured humidity, valid while pronto_medida=1.
- medir_dht11  out  1  1-cycle measurement request pulse.
- rele  out  1  cooling relay command.
- duty_ventoinha  out  2  fan level: 0 off, 1 low, 2 mid, 3 max.
- posicao_servo  out  2  vent servo position, 0..2.
- erro_sensor  out  1  sensor failure latched.
- falhas  out  2  consecutive failure count.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset (reset=0, asynchronous): state INICIAL; all outputs 0; counters, latched measurement and rele history all 0.
- All outputs are registered.
- State codes:
  - INICIAL = 0
  - ESPERA = 1
  - MEDIR = 2
  - AGUARDA = 3
  - AVALIA = 4
  - ATUALIZA = 5
  - FALHA = 6
  - ERRO = 15
- liga=0 in any state: next state INICIAL; rele, duty_ventoinha, posicao_servo and erro_sensor clear; falhas clears. This has priority over every other transition.
- INICIAL: period counter zeroed. Goes to ESPERA when liga=1 and config_valida=1.
- ESPERA: period counter increments each cycle. At count PERIODO_MEDIDA-1: counter clears, go to MEDIR. Outputs hold their last values.
- MEDIR: medir_dht11=1 for exactly this cycle; timeout counter clears; go to AGUARDA.
- AGUARDA: timeout counter increments each cycle.
  - pronto_medida=1: latch temperatura and umidade, go to AVALIA.
  - Otherwise, erro_medida=1, or timeout count reaching TIMEOUT_MEDIDA-1: go to FALHA.
  - pronto_medida and erro_medida both high in the same cycle: pronto wins.
- AVALIA: thresholds are sampled this cycle; rule results computed combinationally from the latched values; falhas cleared.
- ATUALIZA: rule results written to the outputs (one cycle after AVALIA); go to ESPERA. Output latency from the pronto_medida pulse is exactly 2 cycles.
- Rule, rele (compare as unsigned 8-bit):
  - Set to 1 if T >= temp_limite.
  - Cleared to 0 if T < temp_limite - histerese. The subtraction saturates at 0, so with saturation at 0 the relay never clears.
  - Otherwise holds its previous value.
- Rule, duty_ventoinha, with d = T - temp_limite:
  - 0 if T < temp_limite.
  - 1 if d is 0..1.
  - 2 if d is 2..4.
  - 3 if d >= 5.
- Rule, posicao_servo (compare as unsigned 8-bit):
  - 0 if H < umid_limite.
  - 1 if H < umid_limite + 10. The addition saturates at 255.
  - 2 otherwise.
- FALHA: falhas increments, saturating at MAX_FALHAS.
  - If the incremented value equals MAX_FALHAS: go to ERRO.
  - Otherwise go to ESPERA; outputs keep their last valid values.
- ERRO (fail-safe): rele=0, duty_ventoinha=3, posicao_servo=2, erro_sensor=1. Left only via reset or liga=0.
- config_valida falling outside INICIAL: ignored; the next AVALIA uses the current register values.

Test Plan:
- Reset with liga=1, config_valida=1 → all outputs 0; medir_dht11 pulses once, one cycle, PERIODO_MEDIDA+1 cycles after reset release (use PERIODO_MEDIDA=20 and TIMEOUT_MEDIDA=10 in sim).
- temp_limite=25, histerese=2; pronto_medida with T=27, H=40, umid_limite=60 → 2 cycles later rele=1, duty_ventoinha=2, posicao_servo=0.
- Hysteresis sequence T=26, then 24, then 22 → rele stays 1, stays 1, then goes 0; duty_ventoinha goes 1, then 0, then 0.
- No pronto_medida for 10 cycles, three times in a row → falhas reads 1, 2, then state ERRO with rele=0, duty_ventoinha=3, posicao_servo=2, erro_sensor=1; liga=0 → INICIAL with outputs 0.
- pronto_medida and erro_medida high in the same cycle with H=255, umid_limite=250 → treated as success, posicao_servo=2, falhas=0.
- Asynchronous reset asserted mid-AGUARDA without a clock edge → outputs 0 immediately; no medir_dht11 pulse until a full period has elapsed after release.
